digit_scan: RTL

Time-multiplexed scan controller for an N-digit common-select 7-segment display. It buffers a packed hex/BCD value, rotates through the digits, and drives two things: a 4-bit digit code into the hex-to-segment decoder directly downstream, and a one-hot digit-select bus to the display. A shadow/pending double buffer makes value updates tear-free, taking effect only at frame boundaries. Configurable inter-digit blanking suppresses ghosting, and optional leading-zero suppression is provided.

---
 rtl/digit_scan_pkg.sv | 20 ++
 rtl/digit_scan_prescaler.sv | 78 +++++++
 rtl/digit_scan.sv | 121 ++++++++++++
 3 files changed

// File: rtl/digit_scan_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package digit_scan_pkg;

  // Code the downstream decoder renders as a dash; codes pass through untouched.
  localparam logic [3:0] CODE_DASH = 4'hA;

  // Default timing: clk cycles per digit slot and blanked cycles at slot start.
  localparam int DEF_N_DIGITS     = 4;
  localparam int DEF_SCAN_DIV     = 50000;
  localparam int DEF_BLANK_CYCLES = 16;

  // Phase within a digit slot: selects forced off, then the digit is shown.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } phase_e;

endpackage

// File: rtl/digit_scan_prescaler.sv
// Slot counter pair (cnt within slot, idx of digit) plus the BLANK/SHOW phase FSM.
// Latency: slot_start/frame_start/idx_next/show_next describe the state the next edge enters.
// Backpressure: none; free-running from reset release.
module scan_prescaler
  import digit_scan_pkg::*;
#(
  parameter int N_DIGITS     = DEF_N_DIGITS,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             slot_start,
  output logic             frame_start,
  output logic [IDX_W-1:0] idx_next,
  output logic             show_next
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  phase_e           phase;
  phase_e           phase_nxt;

  // The coming edge leaves the last cycle of a slot; entering slot 0 marks a frame.
  assign slot_start  = (cnt == CNT_LAST);
  assign frame_start = slot_start && (idx == IDX_LAST);

  // Digit index advances on slot wrap, ascending and wrapping back to 0.
  always_comb begin
    idx_next = idx;
    if (slot_start) begin
      idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Slot counter and digit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_start ? '0 : cnt + 1'b1;
      idx <= idx_next;
    end
  end

  // Phase state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= BLANK;
    end else begin
      phase <= phase_nxt;
    end
  end

  // Next phase: SHOW once BLANK_CYCLES have elapsed, back to BLANK on every slot wrap.
  always_comb begin
    phase_nxt = phase;
    case (phase)
      BLANK:   if (cnt == BLANK_END) phase_nxt = SHOW;
      SHOW:    if (slot_start)       phase_nxt = BLANK;
      default: phase_nxt = BLANK;
    endcase
  end

  // Phase output: lets the owner of the registered select compute its next value.
  always_comb begin
    show_next = (phase_nxt == SHOW);
  end

endmodule

// File: rtl/digit_scan.sv
// Scan controller: tear-free shadow/pending value buffer, digit rotation, lz suppression.
// Latency: all outputs registered; a load reaches the display at the next slot-0 entry.
// Backpressure: none; load always accepted, last load before a frame edge wins.
module digit_scan
  import digit_scan_pkg::*;
#(
  parameter int N_DIGITS     = DEF_N_DIGITS,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  lz_en,
  output logic [3:0]            code,
  output logic [N_DIGITS-1:0]   sel,
  output logic                  frame,
  output logic                  pending
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef logic [N_DIGITS-1:0][3:0] digits_t;

  logic             slot_start;
  logic             frame_start;
  logic [IDX_W-1:0] idx_next;
  logic             show_next;

  digits_t               value_d;
  digits_t               shadow;
  digits_t               shadow_nxt;
  digits_t               pend_buf;
  logic                  pend_vld;
  logic                  transfer;
  logic [N_DIGITS-1:0]   zero_from;
  logic                  hidden;
  logic [N_DIGITS-1:0]   sel_d;

  scan_prescaler #(
    .N_DIGITS     (N_DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk         (clk),
    .rst_n       (rst_n),
    .slot_start  (slot_start),
    .frame_start (frame_start),
    .idx_next    (idx_next),
    .show_next   (show_next)
  );

  assign value_d = value;

  // Pending value moves into the display only on the edge entering slot 0.
  assign transfer   = frame_start && pend_vld;
  assign shadow_nxt = transfer ? pend_buf : shadow;

  // Displayed value register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else begin
      shadow <= shadow_nxt;
    end
  end

  // Pending buffer: a load on the transfer edge re-arms it with the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_buf <= '0;
      pend_vld <= 1'b0;
    end else if (load) begin
      pend_buf <= value_d;
      pend_vld <= 1'b1;
    end else if (transfer) begin
      pend_vld <= 1'b0;
    end
  end

  // zero_from[i]: digits i..N_DIGITS-1 of the displayed value are all zero.
  always_comb begin
    zero_from = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      zero_from[i] = 1'b1;
      for (int j = i; j < N_DIGITS; j++) begin
        if (shadow[j] != 4'h0) zero_from[i] = 1'b0;
      end
    end
  end

  // Next select: one-hot digit in SHOW unless it is a suppressed leading zero.
  // The shadow only changes on entry to a BLANK cycle, so the current shadow is
  // the right one whenever the next cycle is SHOW.
  always_comb begin
    hidden = lz_en && (idx_next != '0) && zero_from[idx_next];
    sel_d  = '0;
    if (show_next && !hidden) begin
      sel_d[idx_next] = 1'b1;
    end
  end

  // Output registers; code moves only on slot entry, which is always a blanked cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code  <= 4'h0;
      sel   <= '0;
      frame <= 1'b0;
    end else begin
      if (slot_start) begin
        code <= shadow_nxt[idx_next];
      end
      sel   <= sel_d;
      frame <= frame_start;
    end
  end

  assign pending = pend_vld;

endmodule
